// File: rtl/pool_if.sv
// Bundles the pool_ctrl stream, line-buffer and status signals.
//   master : environment side (conv stream source, pooled sink, line buffer)
//   slave  : pool_ctrl side
// Signals:
//   start, in_valid, in_data, in_ready   - frame start and input pixel stream
//   out_valid, out_data                  - pooled pixel output, no backpressure
//   buf_wr_en, buf_wr_data               - line buffer write port
//   buf_rd_en, buf_rd_data               - line buffer read port (data 1 cycle after strobe)
//   busy, done                           - frame status
interface pool_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                         start;
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         buf_wr_en;
  logic signed [DATA_WIDTH-1:0] buf_wr_data;
  logic                         buf_rd_en;
  logic signed [DATA_WIDTH-1:0] buf_rd_data;
  logic                         busy;
  logic                         done;

  modport master (
    output start, in_valid, in_data, buf_rd_data,
    input  in_ready, out_valid, out_data, buf_wr_en, buf_wr_data, buf_rd_en, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, buf_rd_data,
    output in_ready, out_valid, out_data, buf_wr_en, buf_wr_data, buf_rd_en, busy, done
  );
endinterface

// File: rtl/pool_ctrl.sv
// 2x2 / stride-2 signed max-pooling sequencer for one channel of a streamed feature map.
// Even input rows store horizontal pair maxima into an external FIFO line buffer of
// ROW_LEN/2 entries; odd rows read them back and emit one pooled pixel per 2x2 window.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (shared with the line buffer pointers)
//   bus   - pool_if slave: start, input stream, pooled output, buffer ports, busy/done
module pool_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_LEN    = 20,
  parameter int unsigned ROW_CNT    = 20,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input logic   clk,
  input logic   rst_n,
  pool_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StEvenRow, StOddRow, StRdWait, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] LastCol = CNT_WIDTH'(ROW_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] LastRow = CNT_WIDTH'(ROW_CNT - 1);

  state_e                       state_q, state_d;
  logic [CNT_WIDTH-1:0]         col_q, col_d;
  logic [CNT_WIDTH-1:0]         row_q, row_d;
  logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
  logic signed [DATA_WIDTH-1:0] bufreg_q, bufreg_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         wr_en_q, wr_en_d;
  logic signed [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                         done_q, done_d;
  logic                         ready;
  logic                         rd_en;

  // Signed max, strict greater-than; on a tie both operands are equal anyway.
  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    bufreg_d    = bufreg_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    // done is registered off StDone so it lands one cycle after the final out_valid.
    done_d      = (state_q == StDone);
    ready       = 1'b0;
    rd_en       = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StEvenRow;
          col_d   = '0;
          row_d   = '0;
        end
      end

      StEvenRow: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          if (!col_q[0]) begin
            hold_d = bus.in_data;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = smax(hold_q, bus.in_data);
          end
          if (col_q == LastCol) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            state_d = StOddRow;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      StOddRow: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          if (!col_q[0]) begin
            // Even column is never the last one since ROW_LEN is even.
            hold_d  = bus.in_data;
            rd_en   = 1'b1;
            col_d   = col_q + 1'b1;
            state_d = StRdWait;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = smax(smax(hold_q, bus.in_data), bufreg_q);
            if (col_q == LastCol) begin
              col_d = '0;
              if (row_q == LastRow) begin
                row_d   = '0;
                state_d = StDone;
              end else begin
                row_d   = row_q + 1'b1;
                state_d = StEvenRow;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end

      StRdWait: begin
        // Buffer data arrives exactly one cycle after the read strobe.
        bufreg_d = bus.buf_rd_data;
        state_d  = StOddRow;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      bufreg_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      bufreg_q    <= bufreg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.buf_rd_en   = rd_en;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.buf_wr_en   = wr_en_q;
  assign bus.buf_wr_data = wr_data_q;
  assign bus.done        = done_q;
  // Stay busy through the done pulse so busy falls the cycle after done.
  assign bus.busy        = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: a 4x2 instance for small directed frames and a
// 20x20 instance for random frames, each with a FIFO line-buffer model. Expected buffer
// writes and pooled pixels are queued when a frame is generated and popped on DUT output.
module tb_pool_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pool_if #(.DATA_WIDTH(16)) bus_s ();
  pool_if #(.DATA_WIDTH(16)) bus_b ();

  pool_ctrl #(.DATA_WIDTH(16), .ROW_LEN(4), .ROW_CNT(2), .CNT_WIDTH(5)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  pool_ctrl #(.DATA_WIDTH(16), .ROW_LEN(20), .ROW_CNT(20), .CNT_WIDTH(5)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Shared stimulus, steered to the selected instance.
  logic               sel = 1'b0;
  logic               start_r = 1'b0;
  logic               in_valid_r = 1'b0;
  logic signed [15:0] in_data_r = '0;

  assign bus_s.start    = start_r & ~sel;
  assign bus_b.start    = start_r & sel;
  assign bus_s.in_valid = in_valid_r & ~sel;
  assign bus_b.in_valid = in_valid_r & sel;
  assign bus_s.in_data  = in_data_r;
  assign bus_b.in_data  = in_data_r;

  logic               o_valid, o_ready, o_busy, o_done, o_wr, o_rd;
  logic signed [15:0] o_data, o_wd;
  assign o_valid = sel ? bus_b.out_valid : bus_s.out_valid;
  assign o_ready = sel ? bus_b.in_ready : bus_s.in_ready;
  assign o_busy  = sel ? bus_b.busy : bus_s.busy;
  assign o_done  = sel ? bus_b.done : bus_s.done;
  assign o_wr    = sel ? bus_b.buf_wr_en : bus_s.buf_wr_en;
  assign o_rd    = sel ? bus_b.buf_rd_en : bus_s.buf_rd_en;
  assign o_data  = sel ? bus_b.out_data : bus_s.out_data;
  assign o_wd    = sel ? bus_b.buf_wr_data : bus_s.buf_wr_data;

  // Line buffer models: FIFO of ROW_LEN/2 entries, read data valid 1 cycle after strobe.
  logic [1:0]         bwr, brd;
  logic signed [15:0] bwd [2];
  logic signed [15:0] rdq [2];
  logic signed [15:0] mem [2][10];
  int                 wp [2], rp [2], occ [2];
  int                 uflow [2] = '{0, 0};

  assign bwr    = {bus_b.buf_wr_en, bus_s.buf_wr_en};
  assign brd    = {bus_b.buf_rd_en, bus_s.buf_rd_en};
  assign bwd[0] = bus_s.buf_wr_data;
  assign bwd[1] = bus_b.buf_wr_data;
  assign bus_s.buf_rd_data = rdq[0];
  assign bus_b.buf_rd_data = rdq[1];

  function automatic int half_of(input int k);
    return (k == 1) ? 10 : 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wp[k]  <= 0;
        rp[k]  <= 0;
        occ[k] <= 0;
        rdq[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (bwr[k]) begin
          mem[k][wp[k]] <= bwd[k];
          wp[k] <= (wp[k] == half_of(k) - 1) ? 0 : wp[k] + 1;
        end
        if (brd[k]) begin
          rdq[k] <= mem[k][rp[k]];
          rp[k]  <= (rp[k] == half_of(k) - 1) ? 0 : rp[k] + 1;
          if (occ[k] == 0) uflow[k] <= uflow[k] + 1;
        end else begin
          rdq[k] <= '0;
        end
        occ[k] <= occ[k] + int'(bwr[k]) - int'(brd[k]);
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and monitor state.
  int  exp_out[$];
  int  exp_wr[$];
  bit  mon_en = 1'b0;
  bit  rd_prev = 1'b0;
  int  n_out = 0, n_done = 0, n_stall = 0, n_ovf = 0;
  int  last_out_cyc = 0, done_cyc = 0;
  bit  tmo = 1'b0;
  logic signed [15:0] pix [400];

  task automatic mon_step();
    int e;
    if (!mon_en) begin
      rd_prev = 1'b0;
      return;
    end
    if (o_valid) begin
      if (exp_out.size() == 0) begin
        check("out_extra", int'(o_valid), 0);
      end else begin
        e = exp_out.pop_front();
        check("out_data", int'(o_data), e);
      end
      n_out++;
      last_out_cyc = cyc;
    end
    if (o_wr) begin
      if (exp_wr.size() == 0) begin
        check("wr_extra", int'(o_wr), 0);
      end else begin
        e = exp_wr.pop_front();
        check("buf_wr_data", int'(o_wd), e);
      end
    end
    if (rd_prev) check("rdwait_ready", int'(o_ready), 0);
    rd_prev = o_rd;
    if (o_busy && !o_ready) n_stall++;
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
      check("done_busy", int'(o_busy), 1);
    end
    if (n_done > 0 && cyc == done_cyc + 1) check("busy_fall", int'(o_busy), 0);
    if (occ[sel] > half_of(int'(sel))) n_ovf++;
  endtask

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference 2x2 max model: queue the expected buffer writes and pooled pixels.
  task automatic push_expect(input int nr, input int nc);
    int w;
    for (int r = 0; r < nr; r += 2) begin
      for (int c = 0; c < nc; c += 2) begin
        w = mx(int'(pix[r*nc+c]), int'(pix[r*nc+c+1]));
        exp_wr.push_back(w);
        exp_out.push_back(mx(w, mx(int'(pix[(r+1)*nc+c]), int'(pix[(r+1)*nc+c+1]))));
      end
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pix[i] = 16'($urandom);
  endtask

  task automatic send_px(input logic signed [15:0] v, input int gap);
    bit acc;
    int guard;
    if (tmo) return;
    while (gap > 0 && $urandom_range(99) < gap) begin
      @(posedge clk);
      #1;
    end
    in_valid_r = 1'b1;
    in_data_r  = v;
    acc        = 1'b0;
    guard      = 0;
    while (!acc && guard <= 50) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid_r = 1'b0;
    if (!acc) begin
      tmo = 1'b1;
      check("accept_timeout", guard, 50);
    end
  endtask

  task automatic pulse_start();
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
  endtask

  // Runs one frame from pix[]; returns #1 into the cycle after done.
  task automatic run_frame(input int nr, input int nc, input int gap, input bit mid_start);
    int b_out   = n_out;
    int b_done  = n_done;
    int b_stall = n_stall;
    int b_ovf   = n_ovf;
    int b_uf    = uflow[sel];
    int g       = 0;
    push_expect(nr, nc);
    pulse_start();
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        if (mid_start && r == 3 && c == 0) pulse_start();
        send_px(pix[r*nc+c], gap);
      end
    end
    while (n_done == b_done && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("done_cnt", n_done - b_done, 1);
    check("n_out", n_out - b_out, (nr / 2) * (nc / 2));
    check("out_q_left", exp_out.size(), 0);
    check("wr_q_left", exp_wr.size(), 0);
    check("done_lat", done_cyc - last_out_cyc, 1);
    check("stall_cycles", n_stall - b_stall, (nr / 2) * (nc / 2) + 2);
    check("buf_overflow", n_ovf - b_ovf, 0);
    check("buf_underflow", uflow[sel] - b_uf, 0);
    exp_out.delete();
    exp_wr.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t1 [8];
    int t2 [8];
    t1 = '{1, 5, 2, 3, 4, 0, 9, -7};
    t2 = '{-8, -3, -6, -9, -5, -4, -2, -10};

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    #2 rst_n = 1'b0;
    #1;
    check("rst_ready_s", int'(bus_s.in_ready), 0);
    check("rst_valid_s", int'(bus_s.out_valid), 0);
    check("rst_busy_s", int'(bus_s.busy), 0);
    check("rst_done_s", int'(bus_s.done), 0);
    check("rst_wr_s", int'(bus_s.buf_wr_en), 0);
    check("rst_rd_s", int'(bus_s.buf_rd_en), 0);
    check("rst_ready_b", int'(bus_b.in_ready), 0);
    check("rst_busy_b", int'(bus_b.busy), 0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
    mon_en = 1'b1;

    // Small directed frames, 4x2.
    sel = 1'b0;
    for (int i = 0; i < 8; i++) pix[i] = 16'(t1[i]);
    run_frame(2, 4, 0, 1'b0);
    idle_cycles(3);
    for (int i = 0; i < 8; i++) pix[i] = 16'(t2[i]);
    run_frame(2, 4, 0, 1'b0);
    idle_cycles(3);

    // Full-size random frames with input gaps; the second also pulses start mid-frame.
    sel = 1'b1;
    idle_cycles(1);
    fill_random(400);
    run_frame(20, 20, 50, 1'b0);
    idle_cycles(3);
    fill_random(400);
    run_frame(20, 20, 30, 1'b1);
    idle_cycles(3);

    // Abandon a frame by reset while in the odd row at column 2.
    mon_en = 1'b0;
    fill_random(400);
    pulse_start();
    for (int i = 0; i < 22; i++) send_px(pix[i], 0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(o_ready), 0);
    check("mid_rst_valid", int'(o_valid), 0);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_done", int'(o_done), 0);
    check("mid_rst_wr", int'(o_wr), 0);
    check("mid_rst_rd", int'(o_rd), 0);
    check("mid_rst_data", int'(o_data), 0);
    check("mid_rst_wdata", int'(o_wd), 0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
    mon_en = 1'b1;
    fill_random(400);
    run_frame(20, 20, 0, 1'b0);
    idle_cycles(3);

    // Back-to-back: second start lands the cycle after done.
    fill_random(400);
    run_frame(20, 20, 20, 1'b0);
    fill_random(400);
    run_frame(20, 20, 0, 1'b0);
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
